// File: rtl/prim_rom_pkg.sv
// Shared types for the ROM macro family: configuration bundle carried to the storage macro.
package prim_rom_pkg;

  typedef struct packed {
    logic       cfg_en;
    logic [3:0] cfg;
  } rom_cfg_t;

  localparam rom_cfg_t ROM_CFG_DEFAULT = '0;

endpackage

// File: rtl/prim_rom.sv
// Single-cycle ROM macro: data for an address presented with req_i appears on rdata_o next cycle.
module prim_rom
  import prim_rom_pkg::*;
#(
  parameter int    Width       = 32,
  parameter int    Depth       = 2048,
  parameter string MemInitFile = "",
  localparam int   Aw          = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic [Aw-1:0]    addr_i,
  output logic [Width-1:0] rdata_o,
  input  rom_cfg_t         cfg_i
);

  logic [Width-1:0] rdata_q;
  logic             unused_cfg;
  logic             unused_init;

  // Contents are an address-derived pattern; each 32-bit slice i uses (addr + i) * golden ratio.
  function automatic logic [Width-1:0] rom_word(input logic [Aw-1:0] a);
    logic [31:0]      chunk;
    logic [Width-1:0] w;
    w = '0;
    for (int i = 0; i < Width; i++) begin
      chunk = ((32'(a) + 32'(i >> 5)) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
      w[i]  = chunk[i[4:0]];
    end
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      rdata_q <= rom_word(addr_i);
    end
  end

  assign rdata_o     = rdata_q;
  assign unused_cfg  = ^cfg_i;
  assign unused_init = (MemInitFile != "");

endmodule

// File: rtl/prim_rom_pipe_fifo.sv
// Fall-through response FIFO: an arriving push is visible on the outputs in the same cycle when empty.
module prim_rom_pipe_fifo #(
  parameter int Width = 32,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = !empty_o || push_i;
  assign data_o  = empty_o ? push_data_i : mem[rd_ptr_q];

  // A push that is consumed while passing through an empty FIFO is never stored.
  always_comb begin
    wr_en    = push_i && !(empty_o && pop_i);
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= push_data_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/prim_rom_pipe.sv
// ROM read port with configurable read latency, credit-limited grant and a fall-through response buffer.
// Valid/ready: a response transfers in any cycle with rvalid_o & rready_i; while rvalid_o is high and
// rready_i is low, rvalid_o and rdata_o hold. A request transfers in any cycle with req_i & gnt_o.
module prim_rom_pipe
  import prim_rom_pkg::*;
#(
  parameter int    Width       = 32,
  parameter int    Depth       = 2048,
  parameter string MemInitFile = "",
  parameter int    Latency     = 1,
  parameter int    RspDepth    = 2,
  localparam int   Aw          = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [Aw-1:0]    addr_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             idle_o,
  input  rom_cfg_t         cfg_i
);

  localparam int CntW = $clog2(RspDepth + 1);

  typedef struct packed {
    logic             valid;
    logic [Width-1:0] data;
  } stage_t;

  if (Latency < 1 || RspDepth < 1) begin : g_param_check
    $error("prim_rom_pipe: Latency and RspDepth must both be at least 1");
  end

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             accept;
  logic             pop;
  logic             rom_valid_q;
  logic [Width-1:0] rom_rdata;
  stage_t           pipe [Latency];
  logic             fifo_valid;
  logic [Width-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_full;

  // cnt covers reads in flight plus buffered responses, so the FIFO can never overflow.
  assign gnt_o  = (cnt_q < CntW'(RspDepth));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;
  assign idle_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!accept && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      rom_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rom_valid_q <= accept;
    end
  end

  prim_rom #(
    .Width      (Width),
    .Depth      (Depth),
    .MemInitFile(MemInitFile)
  ) u_rom (
    .clk_i  (clk_i),
    .req_i  (accept),
    .addr_i (addr_i),
    .rdata_o(rom_rdata),
    .cfg_i  (cfg_i)
  );

  assign pipe[0] = '{valid: rom_valid_q, data: rom_rdata};

  // Only the valid bit of each stage is reset; data simply follows.
  for (genvar i = 1; i < Latency; i++) begin : g_stage
    stage_t stage_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stage_q.valid <= 1'b0;
      end else begin
        stage_q <= pipe[i-1];
      end
    end
    assign pipe[i] = stage_q;
  end

  prim_rom_pipe_fifo #(
    .Width(Width),
    .Depth(RspDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (pipe[Latency-1].valid),
    .push_data_i(pipe[Latency-1].data),
    .pop_i      (pop),
    .valid_o    (fifo_valid),
    .data_o     (fifo_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign rvalid_o = fifo_valid;
  assign rdata_o  = fifo_valid ? fifo_data : '0;

  a_req_known:    assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(req_i));
  a_rready_known: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(rready_i));
  a_cnt_bound:    assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntW'(RspDepth));
  a_rsp_stable:   assert property (@(posedge clk_i) disable iff (rst_i)
                                   (rvalid_o && !rready_i) |=> (rvalid_o && $stable(rdata_o)));

endmodule

// File: tb/tb_prim_rom_pipe.sv
// Bench for prim_rom_pipe: queue-based reference of outstanding reads checked every cycle, plus directed literals.
module tb_prim_rom_pipe;
  import prim_rom_pkg::*;

  localparam int Width    = 32;
  localparam int Depth    = 2048;
  localparam int Latency  = 2;
  localparam int RspDepth = 2;
  localparam int Aw       = $clog2(Depth);

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             req    = 1'b0;
  logic [Aw-1:0]    addr   = '0;
  logic             rready = 1'b1;
  rom_cfg_t         cfg    = ROM_CFG_DEFAULT;
  logic             gnt;
  logic             rvalid;
  logic [Width-1:0] rdata;
  logic             idle;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference: every accepted, not-yet-popped read in request order, with the cycle its data is due.
  logic [Width-1:0] exp_q[$];
  int               due_q[$];

  always #5 clk = ~clk;

  prim_rom_pipe #(
    .Width      (Width),
    .Depth      (Depth),
    .MemInitFile(""),
    .Latency    (Latency),
    .RspDepth   (RspDepth)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .rvalid_o(rvalid),
    .rready_i(rready),
    .rdata_o (rdata),
    .idle_o  (idle),
    .cfg_i   (cfg)
  );

  function automatic logic [31:0] rom_ref(input logic [Aw-1:0] a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_gnt;
    if (rst) begin
      chk_bit("rst_gnt", gnt, 1'b1);
      chk_bit("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      chk_bit("rst_idle", idle, 1'b1);
      exp_q.delete();
      due_q.delete();
    end else begin
      exp_gnt   = (exp_q.size() < RspDepth);
      exp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
      chk_bit("gnt", gnt, exp_gnt);
      chk_bit("idle", idle, exp_q.size() == 0);
      chk_bit("rvalid", rvalid, exp_valid);
      chk("rdata", rdata, exp_valid ? exp_q[0] : 32'h0);
      if (exp_valid && rready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (req && exp_gnt) begin
        exp_q.push_back(rom_ref(addr));
        due_q.push_back(cyc + Latency);
      end
    end
    cyc++;
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Back-to-back reads of 0,1,2 with the consumer always ready.
    req = 1'b1; addr = 0; step();
    addr = 1; step();
    addr = 2;
    @(negedge clk);
    chk_bit("a_rvalid0", rvalid, 1'b1);
    chk("a_rom0", rdata, 32'h5A5A_C3C3);
    chk_bit("a_gnt_full", gnt, 1'b0);
    step();
    @(negedge clk);
    chk("a_rom1", rdata, 32'hC46D_BA7A);
    chk_bit("a_gnt_back", gnt, 1'b1);
    step();
    req = 1'b0;
    @(negedge clk);
    chk_bit("a_gnt_accpop", gnt, 1'b1);
    chk_bit("a_gap", rvalid, 1'b0);
    step();
    @(negedge clk);
    chk("a_rom2", rdata, 32'h6634_30B1);
    repeat (4) step();

    // Backpressure: addresses 5,6,7 with rready low, then release.
    rready = 1'b0;
    req = 1'b1; addr = 5; step();
    addr = 6; step();
    addr = 7;
    @(negedge clk);
    chk_bit("b_gnt_low", gnt, 1'b0);
    chk_bit("b_rvalid", rvalid, 1'b1);
    step();
    @(negedge clk);
    chk("b_hold5", rdata, 32'h4D4F_A35E);
    step();
    rready = 1'b1;
    @(negedge clk);
    chk("b_pop5", rdata, 32'h4D4F_A35E);
    step();
    @(negedge clk);
    chk_bit("b_gnt_ret", gnt, 1'b1);
    chk("b_pop6", rdata, 32'hEF16_1995);
    step();
    req = 1'b0;
    repeat (5) step();

    // Reset with one response buffered and one in flight.
    rready = 1'b0;
    req = 1'b1; addr = 10; step();
    addr = 11; step();
    req = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_bit("r_idle", idle, 1'b1);
    step();
    rst = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_bit("r_no_stale", rvalid, 1'b0);
      step();
    end

    // Random traffic with random backpressure and one reset pulse.
    for (int k = 0; k < 1500; k++) begin
      req    = ($urandom_range(0, 99) < 70);
      addr   = Aw'($urandom_range(0, Depth - 1));
      rready = ($urandom_range(0, 99) < 60);
      rst    = (k == 700);
      step();
    end
    rst = 1'b0;

    // Saturating traffic with the consumer always ready.
    rready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      req  = 1'b1;
      addr = Aw'($urandom_range(0, Depth - 1));
      step();
    end
    req = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
